matrix_scan_driver: RTL and testbench

Parametrised, registered scanner for a ROWS x COLS LED dot matrix. It double-buffers a column-major frame, optionally inverts it for active-low hardware, and drives one column at a time with a programmable dwell. It sits between the character/pattern logic and the matrix pins. A new frame is swapped in only at a frame boundary, so the display never tears.

---
 rtl/matrix_scan_driver.sv | 150 +++++++++++++++
 tb/tb_matrix_scan_driver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed LED dot-matrix scanner with a double-buffered frame and tear-free swap.
// Optional MATRIX_SCAN_GHOST_BLANK_EN inserts one blanked cycle between columns.
module matrix_scan_driver #(
    parameter int ROWS       = 7,
    parameter int COLS       = 5,
    parameter int DWELL      = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] frame_in,
    input  logic                 load_req,
    output logic                 load_ack,
    output logic [COLS-1:0]      col_sel,
    output logic [ROWS-1:0]      row_data,
    output logic                 frame_done
);
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic               POL        = (ACTIVE_LOW != 0);

`ifdef MATRIX_SCAN_GHOST_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, BLANK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif

    state_t                 state_reg, state_next;
    logic [COL_W-1:0]       col_reg, col_next;
    logic [DWELL_W-1:0]     dwell_reg, dwell_next;
    logic [ROWS*COLS-1:0]   active_reg, active_next;
    logic [ROWS*COLS-1:0]   shadow_reg, shadow_next;
    logic                   pending_reg, pending_next;
    logic [COLS-1:0]        col_sel_reg, col_sel_next;
    logic [ROWS-1:0]        row_data_reg, row_data_next;
    logic                   load_ack_reg;
    logic                   frame_done_reg, frame_done_next;
    logic                   boundary;

    // Boundary is judged on the current cycle so a swap still happens if enable drops on it.
    assign boundary = (state_reg == SCAN) && (col_reg == COL_LAST) && (dwell_reg == DWELL_LAST);

    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        dwell_next   = dwell_reg;
        active_next  = active_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;

        if (!enable) begin
            state_next = IDLE;
            col_next   = '0;
            dwell_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = SCAN;
                    col_next   = '0;
                    dwell_next = '0;
                end
                SCAN: begin
                    if (dwell_reg == DWELL_LAST) begin
                        dwell_next = '0;
                        col_next   = (col_reg == COL_LAST) ? '0 : col_reg + COL_W'(1);
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
                        state_next = BLANK;
`endif
                    end else begin
                        dwell_next = dwell_reg + DWELL_W'(1);
                    end
                end
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
                BLANK: state_next = SCAN;
`endif
                default: state_next = IDLE;
            endcase
        end

        // Swap uses the pre-cycle pending/shadow; a load on the same cycle queues behind it.
        if (boundary && pending_reg) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
        end
        if (load_req) begin
            shadow_next  = frame_in;
            pending_next = 1'b1;
        end
    end

    logic [COLS-1:0]            col_onehot;
    logic [COLS-1:0][ROWS-1:0]  active_cols;
    logic [ROWS-1:0]            col_pixels;

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign col_onehot[gi] = (state_next == SCAN) && (col_next == COL_W'(gi));
        end
    endgenerate

    // Outputs are registered from next-state values so they line up with the state register.
    assign active_cols = active_next;
    assign col_pixels  = active_cols[col_next];

    always_comb begin
        col_sel_next    = col_onehot ^ {COLS{POL}};
        row_data_next   = {ROWS{POL}};
        frame_done_next = 1'b0;
        if (state_next == SCAN) begin
            row_data_next   = col_pixels ^ {ROWS{POL}};
            frame_done_next = (col_next == COL_LAST) && (dwell_next == DWELL_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            dwell_reg      <= '0;
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            col_sel_reg    <= {COLS{POL}};
            row_data_reg   <= {ROWS{POL}};
            load_ack_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            dwell_reg      <= dwell_next;
            active_reg     <= active_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            col_sel_reg    <= col_sel_next;
            row_data_reg   <= row_data_next;
            load_ack_reg   <= load_req;
            frame_done_reg <= frame_done_next;
        end
    end

    assign col_sel    = col_sel_reg;
    assign row_data   = row_data_reg;
    assign load_ack   = load_ack_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Randomized self-checking bench for matrix_scan_driver against a position-in-frame model.
// Honours MATRIX_SCAN_GHOST_BLANK_EN when the design is built with it.
module tb_matrix_scan_driver;
    localparam int ROWS       = 7;
    localparam int COLS       = 5;
    localparam int DWELL      = 4;
    localparam int ACTIVE_LOW = 1;
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
    localparam int P = DWELL + 1;
`else
    localparam int P = DWELL;
`endif
    localparam int F = COLS * P;
    localparam int N = ROWS * COLS;
    localparam logic [ROWS-1:0] DARK  = '1;
    localparam logic [COLS-1:0] NOCOL = '1;

    logic            clk = 1'b0;
    logic            reset, enable, load_req;
    logic [N-1:0]    frame_in;
    logic            load_ack, frame_done;
    logic [COLS-1:0] col_sel;
    logic [ROWS-1:0] row_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: whether scanning, cycle position inside the frame, and the two frame buffers.
    logic [N-1:0]    m_active, m_shadow;
    bit              m_pend, m_on, m_ack;
    int              m_pos;
    logic [COLS-1:0] exp_col_sel;
    logic [ROWS-1:0] exp_row;
    logic            exp_done, exp_ack;

    always #5 clk = ~clk;

    matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .ACTIVE_LOW(ACTIVE_LOW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in), .load_req(load_req),
        .load_ack(load_ack), .col_sel(col_sel), .row_data(row_data), .frame_done(frame_done)
    );

    task automatic tick();
        int col, w;
        logic [ROWS-1:0] pix;
        @(posedge clk);
        if (reset) begin
            m_active = '0; m_shadow = '0; m_pend = 0; m_on = 0; m_pos = 0; m_ack = 0;
        end else begin
            if (m_on && (m_pos == F - P + DWELL - 1) && m_pend) begin
                m_active = m_shadow;
                m_pend   = 0;
            end
            if (load_req) begin
                m_shadow = frame_in;
                m_pend   = 1;
            end
            m_ack = load_req;
            if (!enable)    m_on = 0;
            else if (!m_on) begin m_on = 1; m_pos = 0; end
            else            m_pos = (m_pos + 1) % F;
        end
        #1;
        col = m_pos / P;
        w   = m_pos % P;
        exp_ack = m_ack;
        if (!m_on || w >= DWELL) begin
            exp_col_sel = NOCOL; exp_row = DARK; exp_done = 1'b0;
        end else begin
            pix         = ROWS'(m_active >> (col * ROWS));
            exp_col_sel = ~(COLS'(1) << col);
            exp_row     = ~pix;
            exp_done    = (col == COLS - 1) && (w == DWELL - 1);
        end
        cyc++;
    endtask

    function automatic logic [N-1:0] rnd_frame();
        return N'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        reset = 1; enable = 0; load_req = 0; frame_in = '0;
        tick(); tick();
        checks += 4;
        if (col_sel !== NOCOL)  begin failures++; $display("FAIL reset_col_sel got=%b exp=%b", col_sel, NOCOL); end
        if (row_data !== DARK)  begin failures++; $display("FAIL reset_row_data got=%b exp=%b", row_data, DARK); end
        if (load_ack !== 1'b0)  begin failures++; $display("FAIL reset_load_ack got=%b exp=0", load_ack); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        reset = 0;
        tick();
        checks++;
        if (col_sel !== NOCOL || row_data !== DARK) begin
            failures++; $display("FAIL idle_blank col_sel=%b row_data=%b exp %b/%b", col_sel, row_data, NOCOL, DARK);
        end
    endtask

    task automatic test_blank_scan();
        int dcount = 0;
        enable = 1;
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            checks++;
            if (col_sel !== exp_col_sel || row_data !== exp_row || frame_done !== exp_done || load_ack !== exp_ack) begin
                failures++;
                $display("FAIL blank_scan cyc=%0d col_sel=%b/%b row=%b/%b done=%b/%b ack=%b/%b (got/exp)",
                         cyc, col_sel, exp_col_sel, row_data, exp_row, frame_done, exp_done, load_ack, exp_ack);
            end
            if (i == 0) begin
                checks++;
                if (col_sel !== 5'b11110) begin failures++; $display("FAIL first_column got=%b exp=11110", col_sel); end
            end
            if (frame_done === 1'b1) dcount++;
        end
        checks++;
        if (dcount != 3) begin failures++; $display("FAIL frame_done_count got=%0d exp=3", dcount); end
    endtask

    task automatic test_load_mid_frame();
        int lit = 0;
        bit seen = 0;
        repeat ($urandom_range(12, 3)) tick();
        frame_in = N'(1); load_req = 1;
        tick();
        load_req = 0; frame_in = rnd_frame();
        checks++;
        if (load_ack !== 1'b1) begin failures++; $display("FAIL load_ack got=%b exp=1", load_ack); end
        for (int i = 0; i < 3 * F && !(seen && lit >= 0 && i >= F + 1 && exp_col_sel == 5'b11110 && 0); i++) begin
            if (seen && i > 2 * F) break;
            tick();
            checks++;
            if (col_sel !== exp_col_sel || row_data !== exp_row || frame_done !== exp_done || load_ack !== exp_ack) begin
                failures++;
                $display("FAIL load_mid cyc=%0d col_sel=%b/%b row=%b/%b done=%b/%b ack=%b/%b (got/exp)",
                         cyc, col_sel, exp_col_sel, row_data, exp_row, frame_done, exp_done, load_ack, exp_ack);
            end
            if (!seen && row_data !== DARK) begin
                failures++; checks++;
                $display("FAIL dark_before_swap cyc=%0d row_data=%b exp=%b", cyc, row_data, DARK);
            end
            if (seen && col_sel === 5'b11110 && row_data === 7'b1111110) lit++;
            if (exp_done) begin
                if (seen) break;
                seen = 1;
            end
        end
        checks++;
        if (lit != DWELL) begin failures++; $display("FAIL lit_col0 got=%0d exp=%0d", lit, DWELL); end
    endtask

    task automatic test_back_to_back();
        int lit34 = 0, other = 0;
        bit seen = 0;
        if (exp_done) tick();
        frame_in = N'(1) << 7; load_req = 1;
        tick();
        frame_in = N'(1) << 34;
        tick();
        load_req = 0; frame_in = rnd_frame();
        checks++;
        if (load_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack got=%b exp=1", load_ack); end
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            checks++;
            if (col_sel !== exp_col_sel || row_data !== exp_row || frame_done !== exp_done || load_ack !== exp_ack) begin
                failures++;
                $display("FAIL b2b cyc=%0d col_sel=%b/%b row=%b/%b done=%b/%b ack=%b/%b (got/exp)",
                         cyc, col_sel, exp_col_sel, row_data, exp_row, frame_done, exp_done, load_ack, exp_ack);
            end
            if (seen) begin
                if (col_sel === 5'b01111 && row_data === 7'b0111111) lit34++;
                else if (row_data !== DARK) other++;
            end
            if (exp_done) begin
                if (seen) break;
                seen = 1;
            end
        end
        checks += 2;
        if (lit34 != DWELL) begin failures++; $display("FAIL b2b_bit34 got=%0d exp=%0d", lit34, DWELL); end
        if (other != 0)     begin failures++; $display("FAIL b2b_stray_pixels got=%0d exp=0", other); end
    endtask

    task automatic test_load_on_boundary();
        logic [N-1:0] fa, fb, fexp;
        logic [ROWS-1:0] want;
        bit found = 0;
        fa = rnd_frame(); fb = ~fa;
        if (exp_done) tick();
        frame_in = fa; load_req = 1;
        tick();
        load_req = 0;
        for (int i = 0; i < 2 * F && !found; i++) begin
            if (exp_done) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin failures++; $display("FAIL boundary_timeout got=none exp=frame_done"); end
        frame_in = fb; load_req = 1;
        tick();
        load_req = 0; frame_in = rnd_frame();
        for (int k = 0; k < 2 * F; k++) begin
            fexp = (k < F) ? fa : fb;
            if (k % P < DWELL) want = ~ROWS'(fexp >> ((k % F) / P * ROWS));
            else               want = DARK;
            checks++;
            if (row_data !== want || col_sel !== exp_col_sel || frame_done !== exp_done) begin
                failures++;
                $display("FAIL boundary_load k=%0d row=%b/%b col_sel=%b/%b done=%b/%b (got/exp)",
                         k, row_data, want, col_sel, exp_col_sel, frame_done, exp_done);
            end
            tick();
        end
    endtask

    task automatic test_enable_drop();
        bit found = 0;
        logic [COLS-1:0] after;
        for (int i = 0; i < 2 * F && !found; i++) begin
            if (exp_col_sel == 5'b11011) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin failures++; $display("FAIL col2_timeout got=none exp=11011"); end
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (col_sel !== NOCOL || row_data !== DARK || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL disabled_blank cyc=%0d col_sel=%b row=%b done=%b exp %b/%b/0", cyc, col_sel, row_data, frame_done, NOCOL, DARK);
            end
        end
        enable = 1;
        for (int i = 0; i < DWELL; i++) begin
            tick();
            checks++;
            if (col_sel !== 5'b11110 || row_data !== exp_row) begin
                failures++;
                $display("FAIL restart_col0 i=%0d col_sel=%b/11110 row=%b/%b (got/exp)", i, col_sel, row_data, exp_row);
            end
        end
        tick();
        after = (P > DWELL) ? NOCOL : 5'b11101;
        checks++;
        if (col_sel !== after) begin failures++; $display("FAIL restart_advance got=%b exp=%b", col_sel, after); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enable   = ($urandom_range(39, 0) != 0) ? 1'b1 : ~enable;
            load_req = ($urandom_range(9, 0) == 0);
            frame_in = rnd_frame();
            tick();
            checks++;
            if (col_sel !== exp_col_sel || row_data !== exp_row || frame_done !== exp_done || load_ack !== exp_ack) begin
                failures++;
                $display("FAIL random cyc=%0d col_sel=%b/%b row=%b/%b done=%b/%b ack=%b/%b (got/exp)",
                         cyc, col_sel, exp_col_sel, row_data, exp_row, frame_done, exp_done, load_ack, exp_ack);
            end
        end
        load_req = 0; enable = 1;
    endtask

    task automatic test_mid_scan_reset();
        int lit = 0;
        tick();
        if (exp_done) tick();
        frame_in = rnd_frame() | N'(1); load_req = 1;
        tick();
        load_req = 0;
        reset = 1;
        tick();
        checks++;
        if (col_sel !== NOCOL || row_data !== DARK || load_ack !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midscan_reset col_sel=%b row=%b ack=%b done=%b exp %b/%b/0/0", col_sel, row_data, load_ack, frame_done, NOCOL, DARK);
        end
        reset = 0;
        for (int i = 0; i < 2 * F + 2; i++) begin
            tick();
            if (row_data !== DARK) lit++;
        end
        checks++;
        if (lit != 0) begin failures++; $display("FAIL pending_discarded lit_cycles got=%0d exp=0", lit); end
    endtask

    initial begin
        test_reset();
        test_blank_scan();
        test_load_mid_frame();
        test_back_to_back();
        test_load_on_boundary();
        test_enable_drop();
        test_random();
        test_mid_scan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
